// File: rtl/soc_trace_collector_pkg.sv
// rtl/soc_trace_collector_pkg.sv - shared types and constants for the trace event collector
package soc_trace_collector_pkg;

    localparam int EVT_CORE_W = 8;

    // addi x0,x0,K: rd=0, funct3=0, rs1=0, opcode=OP-IMM, imm[11:8]=0
    localparam logic [31:0] SIMCTRL_MASK  = 32'hF00F_FFFF;
    localparam logic [31:0] SIMCTRL_MATCH = 32'h0000_0013;

    localparam logic [7:0] K_EXIT   = 8'd1;
    localparam logic [7:0] K_REPORT = 8'd2;
    localparam logic [7:0] K_PUTC   = 8'd4;

    typedef struct packed {
        logic [EVT_CORE_W-1:0] core;
        logic [7:0]            code;
        logic [31:0]           arg;
        logic [31:0]           pc;
    } trace_event_t;

    function automatic logic is_simctrl(input logic [31:0] insn);
        return ((insn & SIMCTRL_MASK) == SIMCTRL_MATCH) && (insn[27:20] != 8'd0);
    endfunction

endpackage

// File: rtl/soc_trace_event_fifo.sv
// rtl/soc_trace_event_fifo.sv - synchronous FIFO of trace events with valid/ready read side
module soc_trace_event_fifo
    import soc_trace_collector_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         wr_valid,
    input  trace_event_t wr_data,
    output logic         full,
    output logic         rd_valid,
    input  logic         rd_ready,
    output trace_event_t rd_data
);

    localparam int AW = $clog2(DEPTH);

    trace_event_t   mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [AW:0]    count;
    logic           push;
    logic           pop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign rd_valid = (count != '0);
    assign rd_data  = mem[rd_ptr];
    assign pop      = rd_valid && rd_ready;
    // A pop in the same cycle frees the slot being written, so a full FIFO can still accept.
    assign push     = wr_valid && (!full || pop);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

endmodule

// File: rtl/soc_trace_event_collector.sv
// rtl/soc_trace_event_collector.sv - per-core simctrl decode, round-robin merge into one event FIFO
module soc_trace_event_collector
    import soc_trace_collector_pkg::*;
#(
    parameter int NUM_CORES  = 4,
    parameter int ARG_REG    = 3,
    parameter int FIFO_DEPTH = 8,
    parameter int CNT_W      = 16,
    localparam int CORE_W    = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CORES-1:0]    trace_valid,
    input  logic [NUM_CORES*32-1:0] trace_pc,
    input  logic [NUM_CORES*32-1:0] trace_insn,
    input  logic [NUM_CORES-1:0]    trace_wben,
    input  logic [NUM_CORES*5-1:0]  trace_wbreg,
    input  logic [NUM_CORES*32-1:0] trace_wbdata,
    output logic                    evt_valid,
    input  logic                    evt_ready,
    output logic [CORE_W-1:0]       evt_core,
    output logic [7:0]              evt_code,
    output logic [31:0]             evt_arg,
    output logic [31:0]             evt_pc,
    output logic [NUM_CORES-1:0]    core_terminated,
    output logic                    all_terminated,
    output logic                    overflow,
    output logic [CNT_W-1:0]        drop_count
);

    logic [NUM_CORES-1:0] slot_valid;
    logic [NUM_CORES-1:0] grant_vec;
    logic [NUM_CORES-1:0] drop_req;
    logic [NUM_CORES-1:0] exit_hit;
    trace_event_t         slot_evt [NUM_CORES];

    logic                 fifo_full;
    logic                 can_accept;
    logic                 grant_any;
    logic [CORE_W-1:0]    grant_idx;
    logic [CORE_W-1:0]    rr_ptr;
    logic [CORE_W:0]      cand;
    logic [CORE_W:0]      drop_num;
    logic [CNT_W:0]       drop_sum;
    trace_event_t         head;
    logic                 unused_head_core;

    for (genvar i = 0; i < NUM_CORES; i++) begin : g_core
        logic [31:0]  insn;
        logic         match;
        logic [31:0]  shadow;
        logic         slot_v;
        trace_event_t slot_q;
        trace_event_t new_evt;

        assign insn     = trace_insn[32*i +: 32];
        assign match    = trace_valid[i] && is_simctrl(insn);
        // The argument is the shadow as it stood before this cycle's writeback.
        assign new_evt  = '{core: EVT_CORE_W'(i), code: insn[27:20], arg: shadow,
                            pc: trace_pc[32*i +: 32]};
        assign exit_hit[i]   = match && (insn[27:20] == K_EXIT);
        assign drop_req[i]   = match && slot_v && !grant_vec[i];
        assign slot_valid[i] = slot_v;
        assign slot_evt[i]   = slot_q;

        always_ff @(posedge clk) begin
            if (!rst) begin
                shadow <= '0;
                slot_v <= 1'b0;
                slot_q <= '0;
            end else begin
                if (trace_valid[i] && trace_wben[i] &&
                    (trace_wbreg[5*i +: 5] == 5'(ARG_REG))) begin
                    shadow <= trace_wbdata[32*i +: 32];
                end
                if (match && (!slot_v || grant_vec[i])) begin
                    slot_v <= 1'b1;
                    slot_q <= new_evt;
                end else if (grant_vec[i]) begin
                    slot_v <= 1'b0;
                end
            end
        end
    end

    assign can_accept = !fifo_full || (evt_valid && evt_ready);

    // Round-robin search starting at rr_ptr, wrapping modulo NUM_CORES.
    always_comb begin
        grant_any = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = 0; k < NUM_CORES; k++) begin
            cand = {1'b0, rr_ptr} + (CORE_W+1)'(k);
            if (cand >= (CORE_W+1)'(NUM_CORES)) begin
                cand = cand - (CORE_W+1)'(NUM_CORES);
            end
            if (!grant_any && slot_valid[cand[CORE_W-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = cand[CORE_W-1:0];
            end
        end
        grant_any = grant_any && can_accept;
    end

    assign grant_vec = grant_any ? (NUM_CORES'(1) << grant_idx) : '0;

    always_comb begin
        drop_num = '0;
        for (int i = 0; i < NUM_CORES; i++) begin
            drop_num = drop_num + {{CORE_W{1'b0}}, drop_req[i]};
        end
        drop_sum = {1'b0, drop_count} + {{(CNT_W-CORE_W){1'b0}}, drop_num};
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            rr_ptr          <= '0;
            core_terminated <= '0;
            all_terminated  <= 1'b0;
            overflow        <= 1'b0;
            drop_count      <= '0;
        end else begin
            if (grant_any) begin
                rr_ptr <= (grant_idx == CORE_W'(NUM_CORES-1)) ? '0 : grant_idx + 1'b1;
            end
            core_terminated <= core_terminated | exit_hit;
            all_terminated  <= &core_terminated;
            if (|drop_req) begin
                overflow <= 1'b1;
            end
            drop_count <= drop_sum[CNT_W] ? '1 : drop_sum[CNT_W-1:0];
        end
    end

    soc_trace_event_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .resetn   (rst),
        .wr_valid (grant_any),
        .wr_data  (slot_evt[grant_idx]),
        .full     (fifo_full),
        .rd_valid (evt_valid),
        .rd_ready (evt_ready),
        .rd_data  (head)
    );

    // Event fields read as zero whenever nothing is at the head.
    assign evt_core = evt_valid ? head.core[CORE_W-1:0] : '0;
    assign evt_code = evt_valid ? head.code : '0;
    assign evt_arg  = evt_valid ? head.arg  : '0;
    assign evt_pc   = evt_valid ? head.pc   : '0;
    assign unused_head_core = ^head.core;

endmodule

// File: tb/tb_soc_trace_event_collector.sv
// tb/tb_soc_trace_event_collector.sv - directed table and sequence checks for the trace event collector
module tb_soc_trace_event_collector;

    logic         clk;
    logic         rst;
    logic [3:0]   tv;
    logic [127:0] tpc;
    logic [127:0] tinsn;
    logic [3:0]   twben;
    logic [19:0]  twbreg;
    logic [127:0] twbdata;
    logic         evt_valid;
    logic         evt_ready;
    logic [1:0]   evt_core;
    logic [7:0]   evt_code;
    logic [31:0]  evt_arg;
    logic [31:0]  evt_pc;
    logic [3:0]   core_terminated;
    logic         all_terminated;
    logic         overflow;
    logic [15:0]  drop_count;

    int checks;
    int failures;

    logic [31:0] got_core [$];
    logic [31:0] got_pc   [$];
    logic [31:0] got_code [$];
    logic [31:0] got_arg  [$];

    typedef struct {
        int          core;
        logic [31:0] arg;
        logic [31:0] insn;
        logic [31:0] pc;
        logic [31:0] exp_core;
        logic [31:0] exp_code;
        logic [31:0] exp_arg;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t vecs [4];

    soc_trace_event_collector dut (
        .clk             (clk),
        .rst             (rst),
        .trace_valid     (tv),
        .trace_pc        (tpc),
        .trace_insn      (tinsn),
        .trace_wben      (twben),
        .trace_wbreg     (twbreg),
        .trace_wbdata    (twbdata),
        .evt_valid       (evt_valid),
        .evt_ready       (evt_ready),
        .evt_core        (evt_core),
        .evt_code        (evt_code),
        .evt_arg         (evt_arg),
        .evt_pc          (evt_pc),
        .core_terminated (core_terminated),
        .all_terminated  (all_terminated),
        .overflow        (overflow),
        .drop_count      (drop_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_trace();
        tv      = '0;
        tpc     = '0;
        tinsn   = '0;
        twben   = '0;
        twbreg  = '0;
        twbdata = '0;
    endtask

    task automatic drive(input int c, input logic [31:0] pc, input logic [31:0] insn,
                         input logic wben, input logic [4:0] wbreg, input logic [31:0] wbdata);
        tv[c]             = 1'b1;
        tpc[32*c +: 32]   = pc;
        tinsn[32*c +: 32] = insn;
        twben[c]          = wben;
        twbreg[5*c +: 5]  = wbreg;
        twbdata[32*c +: 32] = wbdata;
    endtask

    task automatic do_reset();
        clear_trace();
        rst = 1'b0;
        step();
        rst = 1'b1;
    endtask

    task automatic collect(input int n, input int budget);
        got_core.delete();
        got_pc.delete();
        got_code.delete();
        got_arg.delete();
        for (int c = 0; c < budget; c++) begin
            if (got_core.size() >= n) break;
            if (evt_valid) begin
                got_core.push_back(32'(evt_core));
                got_pc.push_back(evt_pc);
                got_code.push_back(32'(evt_code));
                got_arg.push_back(evt_arg);
            end
            step();
        end
        check("collect_count", 32'(got_core.size()), 32'(n));
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        drive(v.core, 32'h0, 32'h0001_8193, 1'b1, 5'd3, v.arg);
        step();
        clear_trace();
        drive(v.core, v.pc, v.insn, 1'b0, 5'd0, 32'd0);
        step();
        clear_trace();
        check({tag, "_valid_n1"}, 32'(evt_valid), 32'd0);
        step();
        check({tag, "_valid_n2"}, 32'(evt_valid), 32'd1);
        check({tag, "_core"}, 32'(evt_core), v.exp_core);
        check({tag, "_code"}, 32'(evt_code), v.exp_code);
        check({tag, "_arg"}, evt_arg, v.exp_arg);
        check({tag, "_pc"}, evt_pc, v.exp_pc);
        step();
        check({tag, "_popped"}, 32'(evt_valid), 32'd0);
    endtask

    initial begin
        int order_a [4];
        int order_b [4];
        checks    = 0;
        failures  = 0;
        evt_ready = 1'b1;

        vecs[0] = '{0, 32'h0000_0041, 32'h0040_0013, 32'h0000_0100,
                    32'd0, 32'h04, 32'h0000_0041, 32'h0000_0100};
        vecs[1] = '{1, 32'hDEAD_BEEF, 32'h0020_0013, 32'h0000_2000,
                    32'd1, 32'h02, 32'hDEAD_BEEF, 32'h0000_2000};
        vecs[2] = '{3, 32'h0000_0000, 32'h0FF0_0013, 32'hFFFF_FFFC,
                    32'd3, 32'hFF, 32'h0000_0000, 32'hFFFF_FFFC};
        vecs[3] = '{2, 32'h1234_5678, 32'h07F0_0013, 32'h0000_0040,
                    32'd2, 32'h7F, 32'h1234_5678, 32'h0000_0040};
        order_a = '{0, 1, 2, 3};
        order_b = '{2, 3, 0, 1};

        clear_trace();
        rst = 1'b0;
        step();
        step();
        check("rst_evt_valid", 32'(evt_valid), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        check("rst_drop_count", 32'(drop_count), 32'd0);
        check("rst_core_term", 32'(core_terminated), 32'd0);
        check("rst_all_term", 32'(all_terminated), 32'd0);
        rst = 1'b1;
        step();

        for (int r = 0; r < 4; r++) begin
            run_vec(vecs[r], $sformatf("vec%0d", r));
        end

        // Non-matching addi forms carrying a same-cycle x3 write, then arg-before-update.
        drive(2, 32'h300, 32'h0000_0013, 1'b1, 5'd3, 32'd5);
        step();
        clear_trace();
        drive(2, 32'h304, 32'h0040_0093, 1'b1, 5'd3, 32'd5);
        step();
        clear_trace();
        for (int c = 0; c < 4; c++) begin
            check("nomatch_valid", 32'(evt_valid), 32'd0);
            step();
        end
        drive(2, 32'h308, 32'h0040_0013, 1'b1, 5'd3, 32'd9);
        step();
        clear_trace();
        step();
        check("argpre_valid", 32'(evt_valid), 32'd1);
        check("argpre_arg", evt_arg, 32'd5);
        check("argpre_code", 32'(evt_code), 32'd4);
        step();
        drive(2, 32'h30C, 32'h0020_0013, 1'b0, 5'd0, 32'd0);
        step();
        clear_trace();
        step();
        check("argpost_arg", evt_arg, 32'd9);
        step();

        // Round-robin order from pointer 0, then from pointer 2.
        do_reset();
        for (int i = 0; i < 4; i++) drive(i, 32'h10 * i, 32'h0020_0013, 1'b0, 5'd0, 32'd0);
        step();
        clear_trace();
        collect(4, 20);
        for (int k = 0; k < 4 && k < got_core.size(); k++)
            check($sformatf("rr0_core%0d", k), got_core[k], 32'(order_a[k]));
        drive(1, 32'h80, 32'h0020_0013, 1'b0, 5'd0, 32'd0);
        step();
        clear_trace();
        collect(1, 10);
        for (int i = 0; i < 4; i++) drive(i, 32'h10 * i, 32'h0020_0013, 1'b0, 5'd0, 32'd0);
        step();
        clear_trace();
        collect(4, 20);
        for (int k = 0; k < 4 && k < got_core.size(); k++)
            check($sformatf("rr2_core%0d", k), got_core[k], 32'(order_b[k]));

        // Staggered exits.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(i, 32'h500 + i, 32'h0010_0013, 1'b0, 5'd0, 32'd0);
            step();
            clear_trace();
            check($sformatf("term%0d_bits", i), 32'(core_terminated), (32'd1 << (i + 1)) - 32'd1);
            check($sformatf("term%0d_all_now", i), 32'(all_terminated), 32'd0);
            step();
            check($sformatf("term%0d_all_next", i), 32'(all_terminated), (i == 3) ? 32'd1 : 32'd0);
        end
        step();
        step();
        run_vec(vecs[2], "post_term");

        // Backpressure: 12 events from core1 with the consumer stalled.
        evt_ready = 1'b0;
        check("bp_overflow_pre", 32'(overflow), 32'd0);
        drive(1, 32'h0, 32'h0001_8193, 1'b1, 5'd3, 32'hAA);
        step();
        clear_trace();
        for (int j = 0; j < 12; j++) begin
            drive(1, 32'h1000 + 4 * j, 32'h0020_0013, 1'b0, 5'd0, 32'd0);
            step();
            clear_trace();
            if (j >= 1) begin
                check("bp_hold_valid", 32'(evt_valid), 32'd1);
                check("bp_hold_pc", evt_pc, 32'h1000);
                check("bp_hold_arg", evt_arg, 32'hAA);
            end
        end
        step();
        step();
        check("bp_drop_count", 32'(drop_count), 32'd3);
        check("bp_overflow", 32'(overflow), 32'd1);
        evt_ready = 1'b1;
        collect(9, 40);
        for (int k = 0; k < 9 && k < got_pc.size(); k++)
            check($sformatf("bp_pc%0d", k), got_pc[k], 32'h1000 + 32'(4 * k));
        check("bp_drained", 32'(evt_valid), 32'd0);
        check("bp_drop_hold", 32'(drop_count), 32'd3);

        // Reset with 3 events queued and 2 slots occupied.
        evt_ready = 1'b0;
        for (int j = 0; j < 3; j++) begin
            drive(0, 32'h700 + 4 * j, 32'h0020_0013, 1'b0, 5'd0, 32'd0);
            step();
            clear_trace();
        end
        drive(1, 32'h800, 32'h0020_0013, 1'b0, 5'd0, 32'd0);
        drive(2, 32'h900, 32'h0020_0013, 1'b0, 5'd0, 32'd0);
        step();
        clear_trace();
        check("mid_valid_pre", 32'(evt_valid), 32'd1);
        rst = 1'b0;
        step();
        check("mid_evt_valid", 32'(evt_valid), 32'd0);
        check("mid_evt_core", 32'(evt_core), 32'd0);
        check("mid_evt_code", 32'(evt_code), 32'd0);
        check("mid_evt_arg", evt_arg, 32'd0);
        check("mid_evt_pc", evt_pc, 32'd0);
        check("mid_core_term", 32'(core_terminated), 32'd0);
        check("mid_all_term", 32'(all_terminated), 32'd0);
        check("mid_overflow", 32'(overflow), 32'd0);
        check("mid_drop_count", 32'(drop_count), 32'd0);
        rst = 1'b1;
        evt_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            step();
            check("mid_no_stale", 32'(evt_valid), 32'd0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
